inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning instruction-memory word-address width (64 words).
REQ-002 SHALL have parameter MAX_WORDS, default 64, meaning the largest legal load length in words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port in_valid  input  1  byte-stream valid.
REQ-007 SHALL have port in_data  input  8  byte-stream data.
REQ-008 SHALL have port in_ready  output  1  loader can accept a byte.
REQ-009 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-010 SHALL have port wr_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port wr_data  output  32  instruction word to write.
REQ-012 SHALL have port cpu_rst_n  output  1  active-low reset to the CPU; CPU runs only after a complete load.
REQ-013 SHALL have port done  output  1  load complete.
REQ-014 SHALL have port err  output  1  illegal header received.
REQ-015 SHALL have port words_loaded  output  ADDR_W+1  number of words written this session.

Function
REQ-016 SHALL transfer a byte only on a rising edge with in_valid=1 and in_ready=1; at all other times in_data is ignored and not consumed.
REQ-017 SHALL implement states IDLE, HDR, BYTES, WRITE, DONE, ERR.
REQ-018 IDLE: in_ready=0; start=1 -> HDR.
REQ-019 HDR: in_ready=1; accepted byte N; N=0 or N>MAX_WORDS -> ERR; else store N, clear word index and words_loaded, -> BYTES.
REQ-020 BYTES: in_ready=1; assembles four accepted bytes little-endian (k-th byte into bits [8k+7:8k]); the 4th accepted byte -> WRITE.
REQ-021 WRITE: in_ready=0; wr_en=1 for exactly one cycle with wr_addr=word index and wr_data=assembled word; word index and words_loaded increment; if words_loaded reaches N -> DONE, else -> BYTES.
REQ-022 wr_en SHALL assert in the cycle immediately after the 4th byte of a word is accepted (latency 1).
REQ-023 Maximum throughput SHALL be one word per 5 cycles.
REQ-024 DONE: done=1, cpu_rst_n=1, in_ready=0; start=1 -> HDR with done=0 and cpu_rst_n=0 from the next cycle.
REQ-025 ERR: err=1, cpu_rst_n=0, in_ready=0, no writes; start=1 -> HDR with err=0.
REQ-026 start SHALL be ignored in HDR, BYTES and WRITE.
REQ-027 cpu_rst_n SHALL be 0 in every state except DONE.
REQ-028 wr_addr SHALL never exceed MAX_WORDS-1; there is no wrap-around.
REQ-029 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data values outside WRITE are don't-care.
REQ-030 The loader SHALL NOT clear or read memory; locations at or beyond N keep prior contents.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE and, from that edge, in_ready=0, wr_en=0, cpu_rst_n=0, done=0, err=0, words_loaded=0, wr_addr=0, wr_data=0.
REQ-032 Reset mid-session SHALL discard the partial word with no write; words already written stay in memory.
REQ-033 rst_n SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-034 Reset, start, then bytes 0x01,0x33,0x00,0x00,0x00 -> one wr_en pulse with addr 0 and data 0x00000033; done=1, cpu_rst_n=1, words_loaded=1.
REQ-035 N=2, words 0x00002083 and 0x00402103 with random in_valid gaps -> writes to addr 0 then 1 with correct data; in_ready=0 during each WRITE cycle.
REQ-036 Header 0x00, then separately header 0x41 -> err=1, no wr_en, cpu_rst_n=0; start clears err.
REQ-037 N=64 back-to-back -> 64 writes to addr 0..63, last at 63; done=1 and words_loaded=64.
REQ-038 rst_n=0 after 2 bytes of word 2 -> no write for that word; all outputs at reset values from that edge.
REQ-039 start pulsed in BYTES is ignored; start in DONE -> cpu_rst_n=0 next cycle and a new header is accepted.

Source files
------------

// File: rtl/inst_mem_loader.sv
// ---------------------------------------------------------------------------
// inst_mem_loader
// Receives a byte stream (one header byte N followed by N little-endian
// 32-bit words) and writes the words into instruction memory at word
// addresses 0..N-1. The CPU is held in reset until a complete load finishes.
// A header of zero or larger than MAX_WORDS parks the loader in an error
// state with no memory writes. All outputs are registered.
// ---------------------------------------------------------------------------
module inst_mem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  // Word counters need one extra bit so that a full MAX_WORDS load fits.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    BYTES = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  // Datapath state
  logic [CNT_W-1:0]  n_words_r;
  logic [CNT_W-1:0]  words_loaded_r;
  logic [ADDR_W-1:0] word_idx_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       asm_r;

  // Registered outputs
  logic              in_ready_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              cpu_rst_n_r;
  logic              done_r;
  logic              err_r;

  // Decoded conditions
  logic              accept_s;
  logic              hdr_bad_s;
  logic              last_byte_s;
  logic              last_word_s;

  // Joins the three buffered low bytes with the final byte, little-endian.
  function automatic logic [31:0] le_word(input logic [23:0] lo_bytes,
                                          input logic [7:0]  hi_byte);
    le_word = {hi_byte, lo_bytes};
  endfunction

  // Header legality: zero-length and over-long loads are rejected.
  function automatic logic header_illegal(input logic [7:0] hdr);
    header_illegal = (hdr == 8'd0) || (32'(hdr) > 32'(MAX_WORDS));
  endfunction

  // Handshake and sequencing conditions derived from current state.
  always_comb begin
    accept_s    = in_valid && in_ready_r;
    hdr_bad_s   = header_illegal(in_data);
    last_byte_s = (byte_cnt_r == 2'd3);
    last_word_s = ((words_loaded_r + CNT_W'(1)) == n_words_r);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; start is only honoured from IDLE, DONE and ERR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (accept_s) begin
          if (hdr_bad_s) begin
            state_nxt_s = ERR;
          end else begin
            state_nxt_s = BYTES;
          end
        end else begin
          state_nxt_s = HDR;
        end
      end
      BYTES: begin
        if (accept_s && last_byte_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = BYTES;
        end
      end
      WRITE: begin
        if (last_word_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BYTES;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = DONE;
        end
      end
      ERR: begin
        if (start) begin
          state_nxt_s = HDR;
        end else begin
          state_nxt_s = ERR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Header capture, byte assembly, and word/write bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_words_r      <= {CNT_W{1'b0}};
      words_loaded_r <= {CNT_W{1'b0}};
      word_idx_r     <= {ADDR_W{1'b0}};
      byte_cnt_r     <= 2'd0;
      asm_r          <= 24'd0;
      wr_addr_r      <= {ADDR_W{1'b0}};
      wr_data_r      <= 32'd0;
    end else begin
      case (state_r)
        HDR: begin
          if (accept_s && !hdr_bad_s) begin
            n_words_r      <= CNT_W'(in_data);
            words_loaded_r <= {CNT_W{1'b0}};
            word_idx_r     <= {ADDR_W{1'b0}};
            byte_cnt_r     <= 2'd0;
          end
        end
        BYTES: begin
          if (accept_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
              2'd0: asm_r[7:0]   <= in_data;
              2'd1: asm_r[15:8]  <= in_data;
              2'd2: asm_r[23:16] <= in_data;
              2'd3: begin
                // Final byte goes straight into the write-data register so
                // the strobe can follow on the very next cycle.
                wr_data_r <= le_word(asm_r, in_data);
                wr_addr_r <= word_idx_r;
              end
              default: asm_r <= asm_r;
            endcase
          end
        end
        WRITE: begin
          word_idx_r     <= word_idx_r + ADDR_W'(1);
          words_loaded_r <= words_loaded_r + CNT_W'(1);
        end
        default: begin
          byte_cnt_r <= byte_cnt_r;
        end
      endcase
    end
  end

  // Output registers decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      wr_en_r     <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == HDR) || (state_nxt_s == BYTES);
      wr_en_r     <= (state_nxt_s == WRITE);
      cpu_rst_n_r <= (state_nxt_s == DONE);
      done_r      <= (state_nxt_s == DONE);
      err_r       <= (state_nxt_s == ERR);
    end
  end

  assign in_ready     = in_ready_r;
  assign wr_en        = wr_en_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign cpu_rst_n    = cpu_rst_n_r;
  assign done         = done_r;
  assign err          = err_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// ---------------------------------------------------------------------------
// Bench for inst_mem_loader: a driver issues load sessions and pushes the
// expected memory writes into a queue; a monitor pops and compares them
// whenever wr_en is seen. A flat memory image is kept as the reference.
// ---------------------------------------------------------------------------
module tb_inst_mem_loader;

  localparam int ADDR_W    = 6;
  localparam int MAX_WORDS = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_rst_n;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  inst_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rst_n(cpu_rst_n),
    .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] ref_mem[MAX_WORDS];
  logic [31:0] dut_mem[MAX_WORDS];
  logic [31:0] words_buf[MAX_WORDS];
  int          first_acc;
  int          last_acc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      chk("cpu_rst_n_tracks_done", 32'(cpu_rst_n), 32'(done));
      if (wr_en === 1'b1) begin
        dut_mem[wr_addr] = wr_data;
        chk("in_ready_low_in_write", 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
          chk("wr_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte after a random gap; returns the cycle it was taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap,
                           output int acc_cyc);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100 && in_ready !== 1'b1; t++) tick();
    if (in_ready !== 1'b1) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      acc_cyc = -1;
    end else begin
      tick();
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
  endtask

  // One load session. The first npre words come from words_buf, the rest
  // are random. Words written update the reference memory image.
  task automatic run_session(input int n, input int npre, input int max_gap,
                             input bit poke_start);
    int          acc;
    logic [31:0] w;
    bit          legal;
    legal = (n >= 1) && (n <= MAX_WORDS);
    pulse_start();
    chk("hdr_in_ready", 32'(in_ready), 32'd1);
    chk("hdr_err_clear", 32'(err), 32'd0);
    chk("hdr_done_clear", 32'(done), 32'd0);
    chk("hdr_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    send_byte(8'(n), max_gap, acc);
    if (!legal) begin
      chk("err_set", 32'(err), 32'd1);
      chk("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      chk("err_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        in_data = 8'($urandom);
        tick();
      end
      in_valid = 1'b0;
      chk("err_held", 32'(err), 32'd1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = (k < npre) ? words_buf[k] : $urandom;
      for (int b = 0; b < 4; b++) begin
        if (poke_start && k == 0 && b == 2) start = 1'b1;
        send_byte(w[8*b +: 8], max_gap, acc);
        start = 1'b0;
      end
      exp_q.push_back('{addr: k, data: w, due: acc});
      ref_mem[k] = w;
      if (k == 0) first_acc = acc;
      last_acc = acc;
    end
    tick();
    chk("done_set", 32'(done), 32'd1);
    chk("done_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("done_words_loaded", 32'(words_loaded), 32'(n));
    chk("done_in_ready", 32'(in_ready), 32'd0);
    chk("done_err", 32'(err), 32'd0);
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    logic [31:0] w;
    int          n;
    for (int i = 0; i < MAX_WORDS; i++) begin
      ref_mem[i] = 32'd0;
      dut_mem[i] = 32'd0;
    end
    // Reset takes priority over start/in_valid on the same edge.
    rst_n    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    tick();
    tick();
    chk_reset_outputs();
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Single word 0x00000033.
    words_buf[0] = 32'h0000_0033;
    run_session(1, 1, 0, 1'b0);

    // Two words with random valid gaps; start poked mid-word is ignored.
    words_buf[0] = 32'h0000_2083;
    words_buf[1] = 32'h0040_2103;
    run_session(2, 2, 3, 1'b1);

    // Illegal headers, each cleared by the next start.
    run_session(0, 0, 1, 1'b0);
    run_session(65, 0, 1, 1'b0);

    // Full-size back-to-back load: one word every 5 cycles.
    run_session(MAX_WORDS, 0, 0, 1'b0);
    chk("throughput_span", 32'(last_acc - first_acc), 32'(5 * (MAX_WORDS - 1)));

    // Randomized sessions, mostly legal, occasionally an illegal header.
    for (int s = 0; s < 8; s++) begin
      if ($urandom_range(4, 0) == 0) n = int'($urandom_range(255, MAX_WORDS + 1));
      else n = int'($urandom_range(10, 1));
      run_session(n, 0, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

    // Reset after two bytes of the second word: that word is never written.
    pulse_start();
    send_byte(8'd3, 1, acc);
    w = $urandom;
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1, acc);
    exp_q.push_back('{addr: 0, data: w, due: acc});
    ref_mem[0] = w;
    w = $urandom;
    send_byte(w[7:0], 0, acc);
    send_byte(w[15:8], 0, acc);
    rst_n    = 1'b0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = w[23:16];
    tick();
    chk_reset_outputs();
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("post_rst_idle_ready", 32'(in_ready), 32'd0);
    chk("post_rst_words_loaded", 32'(words_loaded), 32'd0);

    // A fresh session after the aborted one still works.
    run_session(2, 0, 2, 1'b0);

    repeat (3) tick();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < MAX_WORDS; i++) begin
      chk($sformatf("mem_image[%0d]", i), dut_mem[i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
